// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation scheduler: FSM states, display condition codes, moisture levels.
// No logic here; the package only holds combinational helpers.
package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DRIP,
    ST_SPRINKLE,
    ST_COOLDOWN,
    ST_FAULT
  } state_t;

  localparam logic [1:0] COND_OFF   = 2'b00;
  localparam logic [1:0] COND_FAULT = 2'b01;
  localparam logic [1:0] COND_DRIP  = 2'b10;
  localparam logic [1:0] COND_SPR   = 2'b11;

  localparam logic [1:0] MOIST_WET   = 2'b00;
  localparam logic [1:0] MOIST_MOIST = 2'b01;
  localparam logic [1:0] MOIST_DRY   = 2'b10;
  localparam logic [1:0] MOIST_VDRY  = 2'b11;

  function automatic logic [1:0] cond_of(state_t s);
    case (s)
      ST_FAULT:    return COND_FAULT;
      ST_DRIP:     return COND_DRIP;
      ST_SPRINKLE: return COND_SPR;
      default:     return COND_OFF;
    endcase
  endfunction

endpackage

// File: rtl/irrigation_scheduler_if.sv
// Sensor, enable and valve/display signals of the irrigation scheduler.
// Plain level signals, no handshake: the scheduler samples inputs every cycle.
interface irrigation_scheduler_if;
  logic       enable_i;
  logic [1:0] moisture_i;
  logic       tank_low_i;
  logic       tank_empty_i;
  logic       cond_bit0_o;
  logic       cond_bit1_o;
  logic       valve_drip_o;
  logic       valve_spr_o;
  logic       alarm_o;

  modport master (
    output enable_i, moisture_i, tank_low_i, tank_empty_i,
    input  cond_bit0_o, cond_bit1_o, valve_drip_o, valve_spr_o, alarm_o
  );

  modport slave (
    input  enable_i, moisture_i, tank_low_i, tank_empty_i,
    output cond_bit0_o, cond_bit1_o, valve_drip_o, valve_spr_o, alarm_o
  );
endinterface

// File: rtl/irrigation_tick_gen.sv
// Free-running 0..TICK_DIV-1 counter; tick is high for the one cycle before it wraps.
// Latency: tick every TICK_DIV cycles from reset release; no backpressure.
module irrigation_tick_gen #(
  parameter int TICK_DIV = 50_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/irrigation_scheduler.sv
// Irrigation mode FSM: synchronised sensors, tick timer with min-on/max-on/cooldown, registered valve and code outputs.
// Latency: 2-cycle sensor synchronisers plus one registered edge; reset clears outputs asynchronously.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int TICK_DIV       = 50_000,
  parameter int SETTLE_TICKS   = 20,
  parameter int MIN_ON_TICKS   = 1000,
  parameter int MAX_ON_TICKS   = 10000,
  parameter int COOLDOWN_TICKS = 3000
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  irrigation_scheduler_if.slave bus
);

  localparam int TW = $clog2(MAX_ON_TICKS + 1);

  logic [1:0]    moist_m, moisture_s;
  logic          low_m, low_s, empty_m, empty_s;
  logic          tick;
  logic [TW-1:0] timer;
  state_t        state, state_nxt;
  logic          keep_timer;
  logic [1:0]    cond_q;
  logic          drip_q, spr_q, alarm_q;

  irrigation_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .tick    (tick)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      {moist_m, low_m, empty_m}    <= '0;
      {moisture_s, low_s, empty_s} <= '0;
    end else begin
      {moist_m, low_m, empty_m}    <= {bus.moisture_i, bus.tank_low_i, bus.tank_empty_i};
      {moisture_s, low_s, empty_s} <= {moist_m, low_m, empty_m};
    end
  end

  logic dry, wet, spr_ok, run_done;
  assign dry      = (moisture_s >= MOIST_DRY);
  assign wet      = (moisture_s <= MOIST_MOIST);
  assign spr_ok   = (moisture_s == MOIST_VDRY) && !low_s;
  assign run_done = (wet && timer >= TW'(MIN_ON_TICKS)) || (timer == TW'(MAX_ON_TICKS));

  always_comb begin
    state_nxt  = state;
    keep_timer = 1'b0;
    if (empty_s) begin
      state_nxt = ST_FAULT;
    end else if (!bus.enable_i && state != ST_FAULT && state != ST_COOLDOWN) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (dry) state_nxt = ST_SETTLE;
        ST_SETTLE: begin
          if (wet)                                          state_nxt = ST_IDLE;
          else if (timer == TW'(SETTLE_TICKS) && dry)       state_nxt = spr_ok ? ST_SPRINKLE : ST_DRIP;
        end
        ST_DRIP:     if (run_done) state_nxt = ST_COOLDOWN;
        ST_SPRINKLE: begin
          if (run_done) begin
            state_nxt = ST_COOLDOWN;
          end else if (low_s) begin
            // Degrading to drip continues the same run, so min/max accounting carries over.
            state_nxt  = ST_DRIP;
            keep_timer = 1'b1;
          end
        end
        ST_COOLDOWN: if (timer == TW'(COOLDOWN_TICKS)) state_nxt = ST_IDLE;
        ST_FAULT:    state_nxt = ST_COOLDOWN;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      timer   <= '0;
      cond_q  <= COND_OFF;
      drip_q  <= 1'b0;
      spr_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state && !keep_timer)
        timer <= '0;
      else if (tick && timer != TW'(MAX_ON_TICKS))
        timer <= timer + 1'b1;
      cond_q  <= cond_of(state_nxt);
      drip_q  <= (state_nxt == ST_DRIP);
      spr_q   <= (state_nxt == ST_SPRINKLE);
      alarm_q <= (state_nxt == ST_FAULT);
    end
  end

  assign bus.cond_bit0_o  = cond_q[0];
  assign bus.cond_bit1_o  = cond_q[1];
  assign bus.valve_drip_o = drip_q;
  assign bus.valve_spr_o  = spr_q;
  assign bus.alarm_o      = alarm_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Bench for irrigation_scheduler with short timing parameters; output changes are checked against a scoreboard queue.
module tb_irrigation_scheduler;

  localparam logic [4:0] V_OFF   = 5'b00000;  // {cond1,cond0,drip,spr,alarm}
  localparam logic [4:0] V_DRIP  = 5'b10100;
  localparam logic [4:0] V_SPR   = 5'b11010;
  localparam logic [4:0] V_FAULT = 5'b01001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  irrigation_scheduler_if bus();

  irrigation_scheduler #(
    .TICK_DIV(4), .SETTLE_TICKS(3), .MIN_ON_TICKS(5), .MAX_ON_TICKS(12), .COOLDOWN_TICKS(4)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad = 0;
  int pcyc = 0;
  int n_chg = 0;
  int last_chg = 0;
  int run_start = 0;
  logic [4:0] sb_q[$];
  logic [4:0] prev = V_OFF;
  logic [4:0] exp_v;
  wire  [4:0] obs = {bus.cond_bit1_o, bus.cond_bit0_o, bus.valve_drip_o, bus.valve_spr_o, bus.alarm_o};

  always @(posedge clk) pcyc <= pcyc + 1;

  // Every output change must match the oldest expected vector.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev = obs;
    end else if (obs !== prev) begin
      prev     = obs;
      n_chg    = n_chg + 1;
      last_chg = pcyc;
      total    = total + 1;
      if (sb_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_change: outputs=%b with nothing expected at cycle %0d", obs, pcyc);
      end else begin
        exp_v = sb_q.pop_front();
        if (obs !== exp_v) begin
          bad = bad + 1;
          $display("FAIL output_vector: got %b, want %b at cycle %0d", obs, exp_v, pcyc);
        end
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic await_chg(input int budget, output int at);
    int tgt;
    int k;
    tgt = n_chg + 1;
    k = 0;
    while (n_chg < tgt && k < budget) begin
      @(posedge clk);
      k++;
    end
    at = (n_chg >= tgt) ? last_chg : -1;
  endtask

  function automatic int span(input int at, input int from);
    return (at < 0) ? -1 : at - from;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable_i = 1'b1;
    bus.moisture_i = 2'b00;
    bus.tank_low_i = 1'b0;
    bus.tank_empty_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== V_OFF) begin
      bad++;
      $display("FAIL reset_outputs: got %b, want %b", obs, V_OFF);
    end
    drive_edge();
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    total++;
    if (obs !== V_OFF) begin
      bad++;
      $display("FAIL idle_wet: got %b, want %b", obs, V_OFF);
    end
  endtask

  task automatic test_drip_min_on();
    int t0, at, t1;
    sb_q.push_back(V_DRIP);
    sb_q.push_back(V_OFF);
    drive_edge();
    bus.moisture_i = 2'b10;
    t0 = pcyc;
    await_chg(40, at);
    total++;
    if (span(at, t0) < 13 || span(at, t0) > 16) begin
      bad++;
      $display("FAIL drip_start: latency %0d cycles, want 13..16", span(at, t0));
    end
    t1 = at;
    repeat (8) @(posedge clk);
    #2;
    bus.moisture_i = 2'b00;
    await_chg(60, at);
    total++;
    if (span(at, t1) < 18 || span(at, t1) > 21) begin
      bad++;
      $display("FAIL drip_min_on: run %0d cycles, want 18..21", span(at, t1));
    end
    repeat (30) @(posedge clk);
  endtask

  task automatic test_sprinkle_max_on();
    int t0, at, s1, o1;
    sb_q.push_back(V_SPR);
    sb_q.push_back(V_OFF);
    sb_q.push_back(V_SPR);
    drive_edge();
    bus.moisture_i = 2'b11;
    t0 = pcyc;
    await_chg(40, at);
    total++;
    if (span(at, t0) < 13 || span(at, t0) > 16) begin
      bad++;
      $display("FAIL spr_start: latency %0d cycles, want 13..16", span(at, t0));
    end
    s1 = at;
    await_chg(80, at);
    total++;
    if (span(at, s1) < 46 || span(at, s1) > 49) begin
      bad++;
      $display("FAIL spr_max_on: run %0d cycles, want 46..49", span(at, s1));
    end
    o1 = at;
    await_chg(60, at);
    total++;
    if (span(at, o1) < 25 || span(at, o1) > 31) begin
      bad++;
      $display("FAIL cooldown_gap: off time %0d cycles, want 25..31", span(at, o1));
    end
    run_start = at;
  endtask

  task automatic test_tank_low();
    int t0, at;
    sb_q.push_back(V_DRIP);
    sb_q.push_back(V_OFF);
    repeat (8) @(posedge clk);
    #2;
    bus.tank_low_i = 1'b1;
    bus.moisture_i = 2'b00;
    t0 = pcyc;
    await_chg(20, at);
    total++;
    if (span(at, t0) !== 3) begin
      bad++;
      $display("FAIL spr_to_drip: latency %0d cycles, want 3", span(at, t0));
    end
    await_chg(60, at);
    total++;
    if (span(at, run_start) < 18 || span(at, run_start) > 21) begin
      bad++;
      $display("FAIL run_timer_kept: run %0d cycles, want 18..21", span(at, run_start));
    end
    repeat (30) @(posedge clk);
    #2;
    bus.tank_low_i = 1'b0;
  endtask

  task automatic test_fault();
    int t0, at, o1, d1;
    sb_q.push_back(V_DRIP);
    sb_q.push_back(V_FAULT);
    sb_q.push_back(V_OFF);
    sb_q.push_back(V_DRIP);
    sb_q.push_back(V_OFF);
    drive_edge();
    bus.moisture_i = 2'b10;
    t0 = pcyc;
    await_chg(40, at);
    total++;
    if (span(at, t0) < 13 || span(at, t0) > 16) begin
      bad++;
      $display("FAIL fault_drip_start: latency %0d cycles, want 13..16", span(at, t0));
    end
    repeat (6) @(posedge clk);
    #2;
    bus.tank_empty_i = 1'b1;
    t0 = pcyc;
    await_chg(10, at);
    total++;
    if (span(at, t0) < 1 || span(at, t0) > 3) begin
      bad++;
      $display("FAIL fault_latency: latency %0d cycles, want 1..3", span(at, t0));
    end
    repeat (4) @(posedge clk);
    #2;
    bus.tank_empty_i = 1'b0;
    t0 = pcyc;
    await_chg(10, at);
    total++;
    if (span(at, t0) !== 3) begin
      bad++;
      $display("FAIL fault_release: latency %0d cycles, want 3", span(at, t0));
    end
    o1 = at;
    await_chg(60, at);
    total++;
    if (span(at, o1) < 25 || span(at, o1) > 31) begin
      bad++;
      $display("FAIL fault_cooldown_gap: off time %0d cycles, want 25..31", span(at, o1));
    end
    d1 = at;
    drive_edge();
    bus.moisture_i = 2'b00;
    await_chg(60, at);
    total++;
    if (span(at, d1) < 18 || span(at, d1) > 21) begin
      bad++;
      $display("FAIL fault_next_run: run %0d cycles, want 18..21", span(at, d1));
    end
    repeat (30) @(posedge clk);
  endtask

  task automatic test_enable();
    int t1, at;
    sb_q.push_back(V_DRIP);
    sb_q.push_back(V_OFF);
    drive_edge();
    bus.moisture_i = 2'b10;
    repeat (6) @(posedge clk);
    #2;
    bus.enable_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    bus.enable_i = 1'b1;
    t1 = pcyc;
    await_chg(40, at);
    total++;
    if (span(at, t1) < 11 || span(at, t1) > 14) begin
      bad++;
      $display("FAIL settle_restart: latency %0d cycles, want 11..14", span(at, t1));
    end
    repeat (4) @(posedge clk);
    #2;
    bus.enable_i = 1'b0;
    t1 = pcyc;
    await_chg(5, at);
    total++;
    if (span(at, t1) !== 1) begin
      bad++;
      $display("FAIL enable_off: latency %0d cycles, want 1", span(at, t1));
    end
    drive_edge();
    bus.moisture_i = 2'b00;
    bus.enable_i = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_async_reset();
    int t0, at;
    sb_q.push_back(V_SPR);
    drive_edge();
    bus.moisture_i = 2'b11;
    t0 = pcyc;
    await_chg(40, at);
    total++;
    if (span(at, t0) < 13 || span(at, t0) > 16) begin
      bad++;
      $display("FAIL reset_spr_start: latency %0d cycles, want 13..16", span(at, t0));
    end
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.valve_spr_o !== 1'b0) begin
      bad++;
      $display("FAIL async_valve_close: valve_spr=%b, want 0", bus.valve_spr_o);
    end
    total++;
    if (obs !== V_OFF) begin
      bad++;
      $display("FAIL async_outputs: got %b, want %b", obs, V_OFF);
    end
    bus.moisture_i = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (obs !== V_OFF) begin
      bad++;
      $display("FAIL post_reset_idle: got %b, want %b", obs, V_OFF);
    end
  endtask

  initial begin
    test_reset();
    test_drip_min_on();
    test_sprinkle_max_on();
    test_tank_low();
    test_fault();
    test_enable();
    test_async_reset();
    total++;
    if (sb_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drained: %0d entries left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
